// File: rtl/decoder_2to4_behav.sv
// -----------------------------------------------------------------------------
// decoder_2to4_behav
//
// Behavioural 2-to-4 line decoder. A 2-bit select code is turned into one
// active line on a purely combinational output. An enable-gated registered
// copy is also provided for synchronous consumers.
//
// Parameters
//   ACTIVE_LOW_OUT : 0 -> the selected line is 1 and the others are 0.
//                    1 -> every bit of out/out_q is inverted, reset value too.
//
// Ports
//   clk     in   1  rising-edge clock for the registered path
//   rst_n   in   1  synchronous active-low reset (priority over en)
//   in      in   2  select code
//   en      in   1  load enable for the registered path
//   out     out  4  combinational decode of in
//   out_q   out  4  registered decode, loaded when en=1
//   valid_q out  1  out_q holds a value loaded since the last reset
// -----------------------------------------------------------------------------
module decoder_2to4_behav #(
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] in,
    input  logic       en,
    output logic [3:0] out,
    output logic [3:0] out_q,
    output logic       valid_q
);

    // Output polarity is applied by XOR with this mask. The registered reset
    // value uses the same mask, so "all inactive" is 0000 or 1111.
    localparam logic [3:0] POL_MASK = ACTIVE_LOW_OUT ? 4'hF : 4'h0;

    logic [3:0] dec_hot;
    logic [3:0] out_q_reg;
    logic       valid_q_reg;

    // One equality compare per line. When in carries X or Z, each compare
    // evaluates to X, so the whole output goes X. No default line is
    // substituted in that case.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            localparam logic [1:0] LINE_CODE = gi;
            assign dec_hot[gi] = (in == LINE_CODE);
        end
    endgenerate

    assign out = dec_hot ^ POL_MASK;

    // Registered copy. The value present on in at the loading edge is the
    // one captured. There is no extra recovery cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q_reg   <= POL_MASK;
            valid_q_reg <= 1'b0;
        end else if (en) begin
            out_q_reg   <= out;
            valid_q_reg <= 1'b1;
        end
    end

    assign out_q   = out_q_reg;
    assign valid_q = valid_q_reg;

endmodule

// File: tb/tb_decoder_2to4_behav.sv
// -----------------------------------------------------------------------------
// tb_decoder_2to4_behav
//
// Drives one active-high instance and one active-low instance with the same
// stimulus. Expected values are written for the active-high polarity. The
// active-low instance is checked against the bitwise inverse of those values.
// -----------------------------------------------------------------------------
module tb_decoder_2to4_behav;

    logic       clk;
    logic       rst_n;
    logic [1:0] in;
    logic       en;
    logic [3:0] out_h, out_q_h;
    logic       valid_q_h;
    logic [3:0] out_l, out_q_l;
    logic       valid_q_l;

    int checks;
    int failures;

    decoder_2to4_behav #(.ACTIVE_LOW_OUT(1'b0)) dut_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .en      (en),
        .out     (out_h),
        .out_q   (out_q_h),
        .valid_q (valid_q_h)
    );

    decoder_2to4_behav #(.ACTIVE_LOW_OUT(1'b1)) dut_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .en      (en),
        .out     (out_l),
        .out_q   (out_q_l),
        .valid_q (valid_q_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] in;
        logic [3:0] exp_out;     // active-high polarity
        logic [3:0] exp_out_q;   // active-high polarity, after the edge
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        in       = 2'b00;

        // Columns: rst_n, en, in, out, out_q after edge, valid_q after edge.
        vecs.push_back('{1'b0, 1'b1, 2'b11, 4'b1000, 4'b0000, 1'b0}); // reset, en=1 ignored
        vecs.push_back('{1'b0, 1'b1, 2'b11, 4'b1000, 4'b0000, 1'b0}); // second reset edge
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'b0100, 4'b0100, 1'b1}); // first load
        vecs.push_back('{1'b1, 1'b0, 2'b01, 4'b0010, 4'b0100, 1'b1}); // hold 1
        vecs.push_back('{1'b1, 1'b0, 2'b01, 4'b0010, 4'b0100, 1'b1}); // hold 2
        vecs.push_back('{1'b1, 1'b0, 2'b01, 4'b0010, 4'b0100, 1'b1}); // hold 3
        vecs.push_back('{1'b0, 1'b1, 2'b10, 4'b0100, 4'b0000, 1'b0}); // mid-run reset
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'b1000, 4'b1000, 1'b1}); // load right after reset
        vecs.push_back('{1'b1, 1'b1, 2'b00, 4'b0001, 4'b0001, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 4'b0010, 4'b0010, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 4'b0100, 4'b0010, 1'b1}); // en low: hold
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'b0100, 4'b0100, 1'b1}); // en rises with new in
        vecs.push_back('{1'b0, 1'b0, 2'b00, 4'b0001, 4'b0000, 1'b0}); // reset with en=0
        vecs.push_back('{1'b1, 1'b0, 2'b11, 4'b1000, 4'b0000, 1'b0}); // no load: stays invalid
        vecs.push_back('{1'b1, 1'b1, 2'b01, 4'b0010, 4'b0010, 1'b1});

        // Hand sequence: combinational sweep at 10 ns spacing. Reset is held
        // and en is low, so only the comb path changes.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_hot;
            in      = 2'(i);
            exp_hot = 4'b0001 << i;
            #9;
            check("sweep_out_hi", out_h, exp_hot);
            check("sweep_out_lo", out_l, ~exp_hot);
            $display("sweep in=%b out_hi=%b out_lo=%b", in, out_h, out_l);
            #1;
        end

        // Align the table to the clock: drive 1 ns after a rising edge.
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst_n;
            en    = vecs[k].en;
            in    = vecs[k].in;
            #1;
            check("out_hi", out_h, vecs[k].exp_out);
            check("out_lo", out_l, ~vecs[k].exp_out);
            @(posedge clk);
            #1;
            check("out_q_hi", out_q_h, vecs[k].exp_out_q);
            check("out_q_lo", out_q_l, ~vecs[k].exp_out_q);
            check("valid_q_hi", {3'b000, valid_q_h}, {3'b000, vecs[k].exp_valid});
            check("valid_q_lo", {3'b000, valid_q_l}, {3'b000, vecs[k].exp_valid});
            $display("vec %0d rst_n=%b en=%b in=%b out=%b out_q=%b valid_q=%b | lo out=%b out_q=%b",
                     k, rst_n, en, in, out_h, out_q_h, valid_q_h, out_l, out_q_l);
        end

        // Hand sequence: reset is asserted on the same edge as a pending load.
        // The load is discarded, and the next enabled edge loads normally.
        rst_n = 1'b1; en = 1'b1; in = 2'b10;
        @(posedge clk); #1;
        check("pre_q_hi", out_q_h, 4'b0100);
        rst_n = 1'b0; en = 1'b1; in = 2'b11;
        @(posedge clk); #1;
        check("rst_q_hi", out_q_h, 4'b0000);
        check("rst_q_lo", out_q_l, 4'b1111);
        check("rst_v_hi", {3'b000, valid_q_h}, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_q_hi", out_q_h, 4'b1000);
        check("post_q_lo", out_q_l, 4'b0111);
        check("post_v_lo", {3'b000, valid_q_l}, 4'b0001);
        $display("reset-over-load seq out_q_hi=%b out_q_lo=%b valid=%b", out_q_h, out_q_l, valid_q_h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
